// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue/control slice.
// ALU_ISSUE_BRANCH_EN (optional) turns on branch resolution for class 01.
package alu_issue_pkg;

    // ALU op codes as understood by the 64-bit combinational ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // op_class encodings
    localparam logic [1:0] CLS_LDST = 2'b00;
    localparam logic [1:0] CLS_BR   = 2'b01;
    localparam logic [1:0] CLS_RTYP = 2'b10;
    localparam logic [1:0] CLS_NOR  = 2'b11;

    // R-type funct3 values
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    // Branch funct3 values
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LTU  = 3'd3,
        BR_GEU  = 3'd4
    } br_kind_e;

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// alu_op_decode: maps {op_class, funct3, funct7_5} to the ALU op code,
// an illegal flag and the branch kind. Pure combinational, reusable.
// ALU_ISSUE_BRANCH_EN: class 01 decodes funct3 into a branch kind;
// otherwise class 01 is a plain SUB and funct3 is ignored.
module alu_op_decode
    import alu_issue_pkg::*;
(
    input  logic [1:0] op_class,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_op,
    output logic       illegal,
    output br_kind_e   br_kind
);

    // Decode table; illegal encodings fall back to ADD
    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        br_kind = BR_NONE;
        case (op_class)
            CLS_LDST: alu_op = ALU_ADD;
            CLS_BR: begin
                alu_op = ALU_SUB;
`ifdef ALU_ISSUE_BRANCH_EN
                case (funct3)
                    F3_BEQ:  br_kind = BR_EQ;
                    F3_BNE:  br_kind = BR_NE;
                    F3_BLTU: br_kind = BR_LTU;
                    F3_BGEU: br_kind = BR_GEU;
                    default: begin
                        alu_op  = ALU_ADD;
                        illegal = 1'b1;
                    end
                endcase
`endif
            end
            CLS_RTYP: begin
                case (funct3)
                    F3_ADDSUB: alu_op = funct7_5 ? ALU_SUB : ALU_ADD;
                    F3_SLL: begin
                        if (funct7_5) illegal = 1'b1;
                        else          alu_op  = ALU_SLL;
                    end
                    F3_OR:   alu_op  = ALU_OR;
                    F3_AND:  alu_op  = ALU_AND;
                    default: illegal = 1'b1;
                endcase
            end
            default: alu_op = ALU_NOR;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue stage in front of the combinational ALU.
// Registers operands/op code on accept, captures the ALU outputs one
// cycle later and holds them behind a valid/ready handshake.
// ALU_ISSUE_BRANCH_EN enables branch resolution (via alu_op_decode);
// without it the decoder never reports a branch, so taken stays 0.
//
// state | meaning
// IDLE  | no work; in_ready = 1
// EXEC  | ALU settling on registered inputs; capture at next edge
// DONE  | result presented; in_ready follows out_ready
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op_class,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_greater,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_branch_taken,
    output logic              out_illegal
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic              illegal_q, illegal_d;
    br_kind_e          br_kind_q, br_kind_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic              out_zero_q, out_zero_d;
    logic              out_taken_q, out_taken_d;
    logic              out_illegal_q, out_illegal_d;

    logic [3:0]        dec_alu_op;
    logic              dec_illegal;
    br_kind_e          dec_br_kind;
    logic              accept;
    logic              taken;

    alu_op_decode u_decode (
        .op_class (op_class),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_op   (dec_alu_op),
        .illegal  (dec_illegal),
        .br_kind  (dec_br_kind)
    );

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Branch condition from the ALU flags of the operation in flight
    always_comb begin
        taken = 1'b0;
        case (br_kind_q)
            BR_EQ:   taken = alu_zero;
            BR_NE:   taken = !alu_zero;
            BR_LTU:  taken = !alu_greater && !alu_zero;
            BR_GEU:  taken = alu_greater || alu_zero;
            default: taken = 1'b0;
        endcase
    end

    // Next-state, operand load on accept and result capture out of EXEC
    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        illegal_d     = illegal_q;
        br_kind_d     = br_kind_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_zero_d    = out_zero_q;
        out_taken_d   = out_taken_q;
        out_illegal_d = out_illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d       = ST_DONE;
                out_valid_d   = 1'b1;
                out_result_d  = illegal_q ? '0 : alu_result;
                out_zero_d    = !illegal_q && alu_zero;
                out_taken_d   = !illegal_q && taken;
                out_illegal_d = illegal_q;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = in_valid ? ST_EXEC : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            alu_a_d   = rs1_data;
            alu_b_d   = rs2_data;
            alu_op_d  = dec_alu_op;
            illegal_d = dec_illegal;
            br_kind_d = dec_br_kind;
        end
    end

    // State and output registers; reset drops any in-flight result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= 4'b0000;
            illegal_q     <= 1'b0;
            br_kind_q     <= BR_NONE;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_zero_q    <= 1'b0;
            out_taken_q   <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            illegal_q     <= illegal_d;
            br_kind_q     <= br_kind_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_zero_q    <= out_zero_d;
            out_taken_q   <= out_taken_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign alu_a            = alu_a_q;
    assign alu_b            = alu_b_q;
    assign alu_op           = alu_op_q;
    assign out_valid        = out_valid_q;
    assign out_result       = out_result_q;
    assign out_zero         = out_zero_q;
    assign out_branch_taken = out_taken_q;
    assign out_illegal      = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural 64-bit ALU attached.
// Honours ALU_ISSUE_BRANCH_EN the same way the design does.
module tb_alu_issue_ctrl;

`ifdef ALU_ISSUE_BRANCH_EN
    localparam bit BR_ON = 1'b1;
`else
    localparam bit BR_ON = 1'b0;
`endif
    localparam int NV = 12;

    typedef struct packed {
        logic [3:0]  op;
        logic [63:0] res;
        logic        zero;
        logic        tk;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [1:0]  cls;
        logic [2:0]  f3;
        logic        f7;
        logic [63:0] a;
        logic [63:0] b;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op_class = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic        funct7_5 = 1'b0;
    logic [63:0] rs1_data = '0;
    logic [63:0] rs2_data = '0;
    logic [63:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        alu_zero, alu_greater;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_result;
    logic        out_zero, out_branch_taken, out_illegal;

    int errors = 0;
    int checks = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(64)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .op_class         (op_class),
        .funct3           (funct3),
        .funct7_5         (funct7_5),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .alu_a            (alu_a),
        .alu_b            (alu_b),
        .alu_op           (alu_op),
        .alu_result       (alu_result),
        .alu_zero         (alu_zero),
        .alu_greater      (alu_greater),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_zero         (out_zero),
        .out_branch_taken (out_branch_taken),
        .out_illegal      (out_illegal)
    );

    // Behavioural ALU seen by the DUT
    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = alu_a << alu_b;
            4'b1100: alu_result = ~(alu_a | alu_b);
            default: alu_result = '0;
        endcase
        alu_zero    = (alu_result == 64'd0);
        alu_greater = (alu_a > alu_b);
    end

    // Reference: what the instruction means, straight from operands
    function automatic exp_t model(input logic [1:0] c, input logic [2:0] f3,
                                   input logic f7, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        e = '0;
        e.op = 4'b0010;
        case (c)
            2'b00: begin e.op = 4'b0010; e.res = a + b; end
            2'b01: begin
                if (!BR_ON) begin
                    e.op = 4'b0110; e.res = a - b;
                end else if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b110 || f3 == 3'b111) begin
                    e.op = 4'b0110; e.res = a - b;
                    if (f3 == 3'b000)      e.tk = (a == b);
                    else if (f3 == 3'b001) e.tk = (a != b);
                    else if (f3 == 3'b110) e.tk = (a < b);
                    else                   e.tk = (a >= b);
                end else e.ill = 1'b1;
            end
            2'b10: begin
                if (f3 == 3'b000)            begin e.op = f7 ? 4'b0110 : 4'b0010; e.res = f7 ? a - b : a + b; end
                else if (f3 == 3'b111)       begin e.op = 4'b0000; e.res = a & b; end
                else if (f3 == 3'b110)       begin e.op = 4'b0001; e.res = a | b; end
                else if (f3 == 3'b001 && !f7) begin e.op = 4'b0111; e.res = (b >= 64) ? 64'd0 : a << b; end
                else e.ill = 1'b1;
            end
            default: begin e.op = 4'b1100; e.res = ~(a | b); end
        endcase
        e.zero = !e.ill && (e.res == 64'd0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input exp_t e);
        chk("out_result", out_result, e.res);
        chk("out_zero", 64'(out_zero), 64'(e.zero));
        chk("out_branch_taken", 64'(out_branch_taken), 64'(e.tk));
        chk("out_illegal", 64'(out_illegal), 64'(e.ill));
    endtask

    task automatic drive_req(input logic [1:0] c, input logic [2:0] f3, input logic f7,
                             input logic [63:0] a, input logic [63:0] b);
        in_valid = 1'b1; op_class = c; funct3 = f3; funct7_5 = f7;
        rs1_data = a; rs2_data = b;
    endtask

    // Full transaction from IDLE: accept, latency, optional hold, retire
    task automatic run_op(input logic [1:0] c, input logic [2:0] f3, input logic f7,
                          input logic [63:0] a, input logic [63:0] b, input exp_t e, input int hold);
        int n;
        drive_req(c, f3, f7, a, b);
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom};
        op_class = 2'($urandom_range(0, 3));
        chk("alu_op", 64'(alu_op), 64'(e.op));
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        chk("valid_early", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("valid_latency", 64'(out_valid), 64'd1);
        check_out(e);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            check_out(e);
        end
        out_ready = 1'b1;
        #1;
        chk("done_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("retired", 64'(out_valid), 64'd0);
    endtask

    initial begin
        exp_t e1, e2;
        logic [1:0]  rc;
        logic [2:0]  rf3;
        logic        rf7;
        logic [63:0] ra, rb;

        vecs[0]  = '{2'b10, 3'b000, 1'b1, 64'd10, 64'd3, '{4'b0110, 64'd7, 1'b0, 1'b0, 1'b0}};
        vecs[1]  = '{2'b01, 3'b000, 1'b0, 64'h55, 64'h55, '{4'b0110, 64'd0, 1'b1, BR_ON, 1'b0}};
        vecs[2]  = '{2'b10, 3'b010, 1'b0, 64'd9, 64'd4, '{4'b0010, 64'd0, 1'b0, 1'b0, 1'b1}};
        vecs[3]  = '{2'b00, 3'b000, 1'b0, 64'd4, 64'd4, '{4'b0010, 64'd8, 1'b0, 1'b0, 1'b0}};
        vecs[4]  = '{2'b11, 3'b101, 1'b1, 64'd0, 64'd0, '{4'b1100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0}};
        vecs[5]  = '{2'b10, 3'b001, 1'b0, 64'd1, 64'd4, '{4'b0111, 64'd16, 1'b0, 1'b0, 1'b0}};
        vecs[6]  = '{2'b10, 3'b001, 1'b1, 64'd1, 64'd4, '{4'b0010, 64'd0, 1'b0, 1'b0, 1'b1}};
        vecs[7]  = '{2'b10, 3'b111, 1'b0, 64'hF0, 64'h3C, '{4'b0000, 64'h30, 1'b0, 1'b0, 1'b0}};
        vecs[8]  = '{2'b10, 3'b110, 1'b0, 64'hF0, 64'h0F, '{4'b0001, 64'hFF, 1'b0, 1'b0, 1'b0}};
        vecs[9]  = '{2'b01, 3'b010, 1'b0, 64'd5, 64'd3,
                     '{BR_ON ? 4'b0010 : 4'b0110, BR_ON ? 64'd0 : 64'd2, 1'b0, 1'b0, BR_ON}};
        vecs[10] = '{2'b01, 3'b110, 1'b0, 64'd3, 64'd5,
                     '{4'b0110, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, BR_ON, 1'b0}};
        vecs[11] = '{2'b10, 3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, '{4'b0010, 64'd0, 1'b1, 1'b0, 1'b0}};

        // Reset values
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        chk("rst_alu_a", alu_a, 64'd0);
        chk("rst_alu_b", alu_b, 64'd0);
        check_out('0);
        #14 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < NV; i++)
            run_op(vecs[i].cls, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, vecs[i].e, 0);

        // Backpressure with a request waiting, then retire+accept in one edge
        e1 = '{4'b0010, 64'd123, 1'b0, 1'b0, 1'b0};
        e2 = '{4'b1100, ~(64'h0F0F | 64'h00FF), 1'b0, 1'b0, 1'b0};
        drive_req(2'b00, 3'b000, 1'b0, 64'd100, 64'd23);
        @(posedge clk); #1;
        drive_req(2'b11, 3'b000, 1'b0, 64'h0F0F, 64'h00FF);
        chk("bp_alu_op1", 64'(alu_op), 64'(e1.op));
        @(posedge clk); #1;
        chk("bp_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_alu_op_stable", 64'(alu_op), 64'(e1.op));
            chk("bp_alu_a_stable", alu_a, 64'd100);
            check_out(e1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_follow", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp_b2b_valid", 64'(out_valid), 64'd0);
        chk("bp_b2b_alu_op", 64'(alu_op), 64'(e2.op));
        chk("bp_b2b_alu_a", alu_a, 64'h0F0F);
        @(posedge clk); #1;
        chk("bp_b2b_valid2", 64'(out_valid), 64'd1);
        check_out(e2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_retired", 64'(out_valid), 64'd0);

        // Reset during EXEC drops the operation
        drive_req(2'b10, 3'b000, 1'b0, 64'd1, 64'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_alu_op", 64'(alu_op), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_valid", 64'(out_valid), 64'd0);
        end
        run_op(2'b00, 3'b000, 1'b0, 64'd4, 64'd4, '{4'b0010, 64'd8, 1'b0, 1'b0, 1'b0}, 0);

        // Randomised traffic against the reference model
        for (int i = 0; i < 150; i++) begin
            rc  = 2'($urandom_range(0, 3));
            rf3 = 3'($urandom_range(0, 7));
            rf7 = 1'($urandom_range(0, 1));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rb = ra;
            if (rc == 2'b10 && rf3 == 3'b001) rb = 64'($urandom_range(0, 70));
            run_op(rc, rf3, rf7, ra, rb, model(rc, rf3, rf7, ra, rb), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
